// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite pixel engine.
package sprite_pkg;

  typedef logic        [9:0]  coord_t;   // screen coordinate as seen on the beam bus
  typedef logic signed [10:0] scoord_t;  // sprite origin, may sit left of / above the screen
  typedef logic signed [11:0] sdelta_t;  // beam minus origin, one bit wider so it cannot wrap

  // Sprite position captured once per frame.
  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   flip;
  } spr_pos_t;

  // True when (dx,dy) falls inside a w x h box anchored at the origin.
  function automatic logic in_box(input sdelta_t dx, input sdelta_t dy,
                                  input int w, input int h);
    return !dx[11] && (dx < $signed(12'(w))) &&
           !dy[11] && (dy < $signed(12'(h)));
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation frame counter: advances one frame every ANIM_DIV frame_start pulses.
module sprite_anim_ctr #(
  parameter  int FRAMES   = 4,
  parameter  int ANIM_DIV = 8,
  localparam int FW       = (FRAMES   > 1) ? $clog2(FRAMES)   : 1,
  localparam int DW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          anim_en,
  output logic [FW-1:0] cur_frame
);

  logic [DW-1:0] div;

  // Divider and frame index only move on frame_start; anim_en=0 parks both at 0.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      div       <= '0;
      cur_frame <= '0;
    end else if (frame_start) begin
      if (!anim_en) begin
        div       <= '0;
        cur_frame <= '0;
      end else if (div == DW'(ANIM_DIV - 1)) begin
        div       <= '0;
        cur_frame <= (cur_frame == FW'(FRAMES - 1)) ? '0 : cur_frame + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_animator.sv
// Sprite pixel engine: beam position -> ROM address -> opaque hit + palette index,
// three cycles from beam input to hit output.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter  int SPR_W      = 25,
  parameter  int SPR_H      = 30,
  parameter  int FRAMES     = 4,
  parameter  int ANIM_DIV   = 8,
  parameter  int IDX_W      = 3,
  parameter  int TRANSP_IDX = 0,
  parameter  int ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES),
  localparam int FW         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  input  logic              flip,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              sprite_hit,
  output logic [IDX_W-1:0]  sprite_idx,
  output logic [FW-1:0]     cur_frame
);

  localparam logic [ADDR_W:0] FRAME_SZ = (ADDR_W + 1)'(SPR_W * SPR_H);
  localparam logic [ADDR_W:0] ROW_SZ   = (ADDR_W + 1)'(SPR_W);

  spr_pos_t          lpos;
  scoord_t           x0, y0;
  sdelta_t           dx, dy, col;
  logic              inbox;
  logic [ADDR_W:0]   frame_base, row_off, col_off;
  logic [2:1]        vld_pipe;
  logic              opaque;

  sprite_anim_ctr #(.FRAMES(FRAMES), .ANIM_DIV(ANIM_DIV)) u_anim (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .cur_frame   (cur_frame)
  );

  // Position is sampled only at frame_start so a whole frame draws from one position.
  always_ff @(posedge vga_clk) begin
    if (reset)            lpos <= '0;
    else if (frame_start) lpos <= '{x: PosX, y: PosY, flip: flip};
  end

  // Box origin can go negative; dx/dy are one bit wider so they never alias
  // a far-edge beam position back into the box.
  assign x0    = scoord_t'({1'b0, lpos.x}) - scoord_t'(SPR_W / 2);
  assign y0    = scoord_t'({1'b0, lpos.y}) - scoord_t'(SPR_H / 2);
  assign dx    = sdelta_t'({2'b00, DrawX}) - sdelta_t'(x0);
  assign dy    = sdelta_t'({2'b00, DrawY}) - sdelta_t'(y0);
  assign col   = lpos.flip ? sdelta_t'(SPR_W - 1) - dx : dx;
  assign inbox = blank && in_box(dx, dy, SPR_W, SPR_H);

  assign frame_base = (ADDR_W + 1)'(cur_frame) * FRAME_SZ;
  assign row_off    = (ADDR_W + 1)'(dy) * ROW_SZ;
  assign col_off    = (ADDR_W + 1)'(col);

  // Stage 1/2: address only updates for in-box pixels; valid bit follows the ROM read.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], inbox};
      if (inbox) rom_addr <= ADDR_W'(frame_base + row_off + col_off);
    end
  end

  assign opaque = vld_pipe[2] && (rom_q != IDX_W'(TRANSP_IDX));

  // Stage 3: key out the transparent index and force the index to 0 off-sprite.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sprite_hit <= 1'b0;
      sprite_idx <= '0;
    end else begin
      sprite_hit <= opaque;
      sprite_idx <= opaque ? rom_q : '0;
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Self-checking bench for sprite_animator: directed scenarios plus a randomized
// stream checked against a behavioural position/animation model.
module tb_sprite_animator;

  localparam int SPR_W = 25, SPR_H = 30, FRAMES = 4, ANIM_DIV = 8;
  localparam int IDX_W = 3, ADDR_W = 12;

  logic              vga_clk = 1'b0;
  logic              reset, frame_start, blank, flip, anim_en;
  logic [9:0]        DrawX, DrawY, PosX, PosY;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q, sprite_idx;
  logic              sprite_hit;
  logic [1:0]        cur_frame;

  int n_tests = 0, n_fail = 0;

  // model state
  int m_px, m_py, m_pulses;
  bit m_flip;

  sprite_animator dut (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .PosX(PosX), .PosY(PosY), .flip(flip), .anim_en(anim_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .sprite_hit(sprite_hit),
    .sprite_idx(sprite_idx), .cur_frame(cur_frame)
  );

  always #5 vga_clk = ~vga_clk;

  // behavioural ROM: address k holds k % 8, one-cycle read
  always @(posedge vga_clk) rom_q <= 3'(rom_addr % 8);

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic m_reset;
    m_px = 0; m_py = 0; m_flip = 0; m_pulses = 0;
  endtask

  function automatic int m_frame();
    return (m_pulses / ANIM_DIV) % FRAMES;
  endfunction

  function automatic bit m_inbox(input int x, input int y, input bit b);
    int dx, dy;
    dx = x - (m_px - SPR_W / 2);
    dy = y - (m_py - SPR_H / 2);
    return b && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H;
  endfunction

  function automatic int m_addr(input int x, input int y);
    int dx, dy;
    dx = x - (m_px - SPR_W / 2);
    dy = y - (m_py - SPR_H / 2);
    return m_frame() * SPR_W * SPR_H + dy * SPR_W + (m_flip ? SPR_W - 1 - dx : dx);
  endfunction

  task automatic pix(input int x, input int y, input bit b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
  endtask

  // one frame_start cycle during blanking; model follows
  task automatic pulse(input int px, input int py, input bit fl, input bit ae);
    PosX = 10'(px); PosY = 10'(py); flip = fl; anim_en = ae;
    frame_start = 1'b1; blank = 1'b0;
    tick;
    frame_start = 1'b0;
    m_px = px; m_py = py; m_flip = fl;
    m_pulses = ae ? m_pulses + 1 : 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; frame_start = 1'b0; anim_en = 1'b1; flip = 1'b0;
    PosX = 10'd100; PosY = 10'd100;
    pix(100, 100, 1'b1);
    tick; tick;
    n_tests++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    n_tests++; if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b want 0", sprite_hit); end
    n_tests++; if (sprite_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", sprite_idx); end
    n_tests++; if (cur_frame !== '0) begin n_fail++; $display("FAIL reset_frame: got %0d want 0", cur_frame); end
    reset = 1'b0;
    m_reset();
    tick;
  endtask

  task automatic test_basic;
    pulse(100, 100, 1'b0, 1'b0);
    pix(88, 85, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd0) begin n_fail++; $display("FAIL basic_addr0: got %0d want 0", rom_addr); end
    pix(89, 85, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd1) begin n_fail++; $display("FAIL basic_addr1: got %0d want 1", rom_addr); end
    tick;
    // pixel (88,85) reaches the output: index 0 is transparent
    n_tests++; if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL basic_transp_hit: got %0b want 0", sprite_hit); end
    tick;
    n_tests++; if (sprite_hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit: got %0b want 1", sprite_hit); end
    n_tests++; if (sprite_idx !== 3'd1) begin n_fail++; $display("FAIL basic_idx: got %0d want 1", sprite_idx); end
  endtask

  task automatic test_flip;
    pulse(100, 100, 1'b1, 1'b0);
    pix(88, 85, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd24) begin n_fail++; $display("FAIL flip_addr: got %0d want 24", rom_addr); end
    pix(89, 85, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd23) begin n_fail++; $display("FAIL flip_addr2: got %0d want 23", rom_addr); end
    tick; tick;
    n_tests++; if (sprite_idx !== 3'd7 || sprite_hit !== 1'b1) begin
      n_fail++; $display("FAIL flip_idx: got hit=%0b idx=%0d want hit=1 idx=7", sprite_hit, sprite_idx);
    end
  endtask

  task automatic test_clip;
    pulse(5, 100, 1'b0, 1'b0);
    pix(0, 85, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd7) begin n_fail++; $display("FAIL clip_addr: got %0d want 7", rom_addr); end
    pix(18, 85, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd7) begin n_fail++; $display("FAIL clip_hold: got %0d want 7", rom_addr); end
    pix(630, 85, 1'b1);
    tick;
    n_tests++; if (sprite_hit !== 1'b1 || sprite_idx !== 3'd7) begin
      n_fail++; $display("FAIL clip_in_hit: got hit=%0b idx=%0d want hit=1 idx=7", sprite_hit, sprite_idx);
    end
    tick;
    n_tests++; if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL clip_right: got %0b want 0", sprite_hit); end
    tick;
    n_tests++; if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL clip_nowrap: got %0b want 0", sprite_hit); end
    n_tests++; if (rom_addr !== 12'd7) begin n_fail++; $display("FAIL clip_wrap_addr: got %0d want 7", rom_addr); end
  endtask

  task automatic test_anim;
    pulse(100, 100, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      pulse(100, 100, 1'b0, 1'b1);
      n_tests++; if (cur_frame !== 2'(m_frame())) begin
        n_fail++; $display("FAIL anim_step%0d: got %0d want %0d", i, cur_frame, m_frame());
      end
      if (i == 8) begin
        n_tests++; if (cur_frame !== 2'd1) begin n_fail++; $display("FAIL anim_frame1: got %0d want 1", cur_frame); end
        pix(88, 85, 1'b1);
        tick;
        n_tests++; if (rom_addr !== 12'd750) begin n_fail++; $display("FAIL anim_addr: got %0d want 750", rom_addr); end
        tick; tick;
        n_tests++; if (cur_frame !== 2'd1) begin n_fail++; $display("FAIL anim_stable: got %0d want 1", cur_frame); end
      end
    end
    n_tests++; if (cur_frame !== 2'd0) begin n_fail++; $display("FAIL anim_wrap: got %0d want 0", cur_frame); end
    for (int i = 0; i < 8; i++) pulse(100, 100, 1'b0, 1'b1);
    pulse(100, 100, 1'b0, 1'b0);
    n_tests++; if (cur_frame !== 2'd0) begin n_fail++; $display("FAIL anim_disable: got %0d want 0", cur_frame); end
  endtask

  task automatic test_tear;
    pulse(200, 200, 1'b0, 1'b0);
    pix(190, 186, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd27) begin n_fail++; $display("FAIL tear_addr: got %0d want 27", rom_addr); end
    PosX = 10'd300; PosY = 10'd50; flip = 1'b1;
    pix(191, 186, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd28) begin n_fail++; $display("FAIL tear_hold: got %0d want 28", rom_addr); end
    pulse(300, 50, 1'b1, 1'b0);
    pix(290, 36, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd47) begin n_fail++; $display("FAIL tear_new: got %0d want 47", rom_addr); end
    pix(191, 186, 1'b1);
    tick;
    n_tests++; if (rom_addr !== 12'd47) begin n_fail++; $display("FAIL tear_old_out: got %0d want 47", rom_addr); end
  endtask

  task automatic test_blank_reset;
    pulse(100, 100, 1'b0, 1'b0);
    pix(89, 85, 1'b0);
    tick; tick; tick;
    n_tests++; if (sprite_hit !== 1'b0 || sprite_idx !== '0) begin
      n_fail++; $display("FAIL blank_hit: got hit=%0b idx=%0d want 0/0", sprite_hit, sprite_idx);
    end
    for (int i = 0; i < 8; i++) pulse(100, 100, 1'b0, 1'b1);
    pix(89, 85, 1'b1);
    tick; tick; tick;
    n_tests++; if (sprite_hit !== 1'b1 || sprite_idx !== 3'd7) begin
      n_fail++; $display("FAIL inflight_hit: got hit=%0b idx=%0d want 1/7", sprite_hit, sprite_idx);
    end
    reset = 1'b1;
    tick;
    n_tests++; if (sprite_hit !== 1'b0 || sprite_idx !== '0 || rom_addr !== '0 || cur_frame !== '0) begin
      n_fail++; $display("FAIL flush: got hit=%0b idx=%0d addr=%0d frame=%0d want all 0",
                         sprite_hit, sprite_idx, rom_addr, cur_frame);
    end
    m_reset();
    pix(1, 0, 1'b1);  // in box around the cleared position (0,0): addr 388, index 4
    tick;
    reset = 1'b0;
    tick;
    n_tests++; if (rom_addr !== 12'd388) begin n_fail++; $display("FAIL post_reset_addr: got %0d want 388", rom_addr); end
    n_tests++; if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL post_reset_1: got %0b want 0", sprite_hit); end
    tick;
    n_tests++; if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL post_reset_2: got %0b want 0", sprite_hit); end
    tick;
    n_tests++; if (sprite_hit !== 1'b1 || sprite_idx !== 3'd4) begin
      n_fail++; $display("FAIL post_reset_3: got hit=%0b idx=%0d want 1/4", sprite_hit, sprite_idx);
    end
  endtask

  task automatic test_random;
    localparam int N = 400;
    int ea[N];
    bit eh[N];
    int ei[N];
    int last, x, y, px, py;
    bit b, fs, fl, ae, inb;
    last = -1;
    for (int c = 0; c < N; c++) begin
      fs = (c % 50 == 0);
      px = (c == 0) ? 320 : $urandom_range(0, 639);
      py = (c == 0) ? 240 : $urandom_range(0, 479);
      fl = $urandom_range(0, 1);
      ae = (c == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (c == 1) begin
        x = m_px; y = m_py; b = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); b = $urandom_range(0, 1);
      end else begin
        x = m_px - SPR_W / 2 - 4 + $urandom_range(0, SPR_W + 7);
        y = m_py - SPR_H / 2 - 4 + $urandom_range(0, SPR_H + 7);
        b = ($urandom_range(0, 4) != 0);
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      if (x > 1023) x = 1023;
      if (y > 1023) y = 1023;
      if (fs) b = 1'b0;
      PosX = 10'(px); PosY = 10'(py); flip = fl; anim_en = ae;
      frame_start = fs;
      pix(x, y, b);
      inb = m_inbox(x, y, b);
      if (inb) last = m_addr(x, y);
      ea[c] = last;
      eh[c] = inb && (last % 8 != 0);
      ei[c] = eh[c] ? last % 8 : 0;
      if (fs) begin
        m_px = px; m_py = py; m_flip = fl;
        m_pulses = ae ? m_pulses + 1 : 0;
      end
      tick;
      if (ea[c] >= 0) begin
        n_tests++; if (rom_addr !== 12'(ea[c])) begin
          n_fail++; $display("FAIL rand_addr c=%0d: got %0d want %0d", c, rom_addr, ea[c]);
        end
      end
      n_tests++; if (cur_frame !== 2'(m_frame())) begin
        n_fail++; $display("FAIL rand_frame c=%0d: got %0d want %0d", c, cur_frame, m_frame());
      end
      if (c >= 2) begin
        n_tests++; if (sprite_hit !== eh[c-2] || sprite_idx !== 3'(ei[c-2])) begin
          n_fail++; $display("FAIL rand_out c=%0d: got hit=%0b idx=%0d want hit=%0b idx=%0d",
                             c, sprite_hit, sprite_idx, eh[c-2], ei[c-2]);
        end
      end
    end
    frame_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_flip();
    test_clip();
    test_anim();
    test_tear();
    test_blank_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
Parametrised, pipelined sprite pixel engine for the VGA path. It produces a ROM address for one animated sprite from the beam position (DrawX/DrawY) and the sprite centre. It then returns an opaque-hit flag and a palette index, both aligned to a fixed pipeline latency. It adds animation frames, horizontal flip, off-screen clipping, transparency keying and tear-free position latching. One instance drives each character sprite; the palette and the priority mixer sit downstream.

Parameters:
SPR_W, 25, sprite width in pixels
SPR_H, 30, sprite height in pixels
FRAMES, 4, animation frames stored back-to-back in the ROM
ANIM_DIV, 8, number of vertical frames per animation step (>=1)
IDX_W, 3, palette index width
TRANSP_IDX, 0, palette index treated as transparent
ADDR_W, $clog2(SPR_W*SPR_H*FRAMES), ROM address width

Ports:
vga_clk  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at the start of vertical blank
DrawX  in  10  current beam X
DrawY  in  10  current beam Y
blank  in  1  1 = active video
PosX  in  10  sprite centre X (live, from motion logic)
PosY  in  10  sprite centre Y
flip  in  1  1 = mirror horizontally (facing left)
anim_en  in  1  1 = cycle through animation frames; 0 = hold frame 0
rom_addr  out  ADDR_W  registered address to the external sprite ROM
rom_q  in  IDX_W  ROM data; the ROM has a one-cycle synchronous read on vga_clk
sprite_hit  out  1  1 = opaque sprite pixel at the delayed beam position
sprite_idx  out  IDX_W  palette index; 0 when sprite_hit = 0
cur_frame  out  $clog2(FRAMES)  current animation frame (debug/status)

Behaviour:
- Reset: rom_addr=0, sprite_hit=0, sprite_idx=0, cur_frame=0. The latched position clears to 0, the animation divider clears to 0, and all pipeline valid bits clear. Reset mid-line flushes the pipeline; the outputs stay 0 until 3 cycles after reset is released.
- Position latch: PosX, PosY and flip are captured only on a cycle with frame_start=1. Geometry for the whole frame uses the latched values, which prevents tearing.
- Animation:
  - Divider counts frame_start pulses 0..ANIM_DIV-1. On wrap, cur_frame increments modulo FRAMES (FRAMES-1 -> 0).
  - If anim_en=0 on a frame_start cycle, the divider and cur_frame both load 0.
  - cur_frame only changes on frame_start cycles.
- Stage 1 (edge N+1):
  - Compute x0 = LPosX - SPR_W/2 and y0 = LPosY - SPR_H/2 as 11-bit signed values (integer division).
  - dx = DrawX - x0, dy = DrawY - y0, both signed.
  - inbox = blank && 0<=dx<SPR_W && 0<=dy<SPR_H. Negative x0/y0 clip correctly; there is no wrap-around to the far screen edge.
  - col = flip ? SPR_W-1-dx : dx.
  - rom_addr <= cur_frame*SPR_W*SPR_H + dy*SPR_W + col when inbox; otherwise rom_addr holds its previous value.
  - v1 <= inbox.
- Stage 2 (edge N+2): the ROM presents rom_q for the stage-1 address. v2 <= v1.
- Stage 3 (edge N+3): sprite_hit <= v2 && (rom_q != TRANSP_IDX); sprite_idx <= that result ? rom_q : 0.
- Latency: beam inputs sampled at edge N appear on sprite_hit/sprite_idx after edge N+3, fixed. The downstream mixer delays DrawX/DrawY and blank by 3 to match.
- frame_start coinciding with active video is illegal. If it does occur, the new position takes effect at the next stage-1 computation.
- All multiplies are by constants. Address arithmetic is done at ADDR_W+1 bits and truncated.

Decomposition:
- Package sprite_pkg holds the typedefs coord_t (logic [9:0]) and scoord_t (logic signed [10:0]), plus the helper function in_box().
- Sub-module sprite_anim_ctr holds the frame_start divider and the frame counter, with ports vga_clk, reset, frame_start, anim_en, cur_frame.
- The top level holds the position latch and the 3-stage pipeline. The ROM is external.

Test Plan:
1. Basic hit and latency (defaults, behavioural ROM, addr k holds k%8; reset; frame_start with PosX=100, PosY=100):
   - DrawX=88, DrawY=85, blank=1 -> rom_addr=0 after 1 edge; sprite_hit=0 after 3 edges (index 0 is transparent).
   - DrawX=89 -> addr 1, sprite_hit=1, sprite_idx=1.
2. Flip: same setup with flip=1 latched; DrawX=88, DrawY=85 -> rom_addr=24.
3. Clipping at the left edge: PosX=5 (x0=-7):
   - DrawX=0 -> addr 7 (inside the box).
   - DrawX=18 -> sprite_hit=0.
   - DrawX=630 -> sprite_hit=0 (no wrap-around).
4. Animation: anim_en=1, 8 frame_start pulses -> cur_frame=1, and DrawX=88, DrawY=85 gives addr 750. After 32 pulses cur_frame returns to 0. One pulse with anim_en=0 -> cur_frame=0.
5. Tear-free latch: change PosX mid-frame with no frame_start -> the address is unchanged until the next frame_start.
6. Blanking and reset: blank=0 inside the box -> sprite_hit=0. Assert reset while hits are in flight -> all outputs are 0 on the next edge and remain 0 until 3 edges after reset is released.
